// File: rtl/instr_prefetch_buffer_pkg.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer_pkg
// Shared types and constants for the instruction prefetch buffer.
//   PREFETCH_DEPTH   : default number of queue entries
//   prefetch_entry_t : one queued word, tagged with its word address
//   PREFETCH_ENTRY_W : flattened width of prefetch_entry_t for ports
//   pf_state_e       : two-state control FSM encoding
// ---------------------------------------------------------------------------
package instr_prefetch_buffer_pkg;

  localparam int PREFETCH_DEPTH = 4;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } prefetch_entry_t;

  localparam int PREFETCH_ENTRY_W = $bits(prefetch_entry_t);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pf_state_e;

endpackage

// File: rtl/instr_prefetch_buffer_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// prefetch_fifo
// In-order queue of prefetch_entry_t with a combinational head read so the
// fetch stage sees a hit in the same cycle it changes its address.
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_push        : write i_push_entry at the tail (ignored when full)
//   i_pop         : drop the head entry (ignored when empty)
//   i_clear       : empty the queue; wins over push and pop
//   o_head        : entry at the head (undefined contents when empty)
//   o_full/o_empty: occupancy flags
//   o_count       : number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module prefetch_fifo
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_push,
  input  logic [PREFETCH_ENTRY_W-1:0] i_push_entry,
  input  logic                        i_pop,
  input  logic                        i_clear,
  output logic [PREFETCH_ENTRY_W-1:0] o_head,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [PW-1:0]               o_count
);

  prefetch_entry_t r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic            w_do_push;
  logic            w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (o_count == PW'(DEPTH));
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= prefetch_entry_t'(i_push_entry);
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer
// Prefetches sequential 32-bit instruction words ahead of the fetch stage and
// presents the queued word that matches the fetch address. A redirect (or a
// head that does not match the fetch address) flushes the queue, restarts the
// stream at the fetch address and turns in-flight responses into discards.
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_fetch_addr   : fetch stage address (bits [1:0] ignored)
//   i_fetch_pop    : fetch consumed the presented word
//   i_redirect     : restart the stream at i_fetch_addr
//   o_instr_data   : head word (0 when the queue is empty)
//   o_instr_valid  : head present and its address matches i_fetch_addr
//   o_mem_req/addr : memory request and word-aligned address
//   i_mem_gnt      : request accepted this cycle
//   i_mem_rvalid/rdata : in-order responses, at least one cycle after grant
// Supports ADDR_W up to 32 (queue tags are 30-bit word addresses).
// ---------------------------------------------------------------------------
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH  = PREFETCH_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  input  logic              i_fetch_pop,
  input  logic              i_redirect,
  output logic [31:0]       o_instr_data,
  output logic              o_instr_valid,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = ADDR_W - 2;
  localparam logic [CW+1:0] SAT_LIM = (CW+2)'((1 << CW) - 1);

  pf_state_e                 r_state;
  logic [WW-1:0]             r_next_waddr;
  logic [WW-1:0]             r_resp_waddr;
  logic [CW-1:0]             r_outstanding;
  logic [CW-1:0]             r_discard;

  logic [WW-1:0]             w_fetch_waddr;
  logic                      w_unused_lsbs;
  logic [PREFETCH_ENTRY_W-1:0] w_head_bits;
  prefetch_entry_t           w_head;
  prefetch_entry_t           w_push_entry;
  logic                      w_full;
  logic                      w_empty;
  logic [CW-1:0]             w_count;
  logic                      w_head_match;
  logic                      w_flush;
  logic                      w_grant;
  logic                      w_rsp_any;
  logic                      w_accept;
  logic                      w_drop;
  logic                      w_pop;
  logic [CW+1:0]             w_discard_sum;
  logic [CW+1:0]             w_out_sum;
  logic [CW-1:0]             w_discard_next;
  logic [CW-1:0]             w_out_next;

  assign w_fetch_waddr = i_fetch_addr[ADDR_W-1:2];
  assign w_unused_lsbs = ^i_fetch_addr[1:0];
  assign w_head        = prefetch_entry_t'(w_head_bits);

  assign w_head_match  = !w_empty && (w_head.waddr == 30'(w_fetch_waddr));
  // A non-matching head means fetch has gone somewhere else: treat it as a
  // redirect so the stream heals itself without help from the fetch stage.
  assign w_flush       = i_redirect || (!w_empty && !w_head_match);

  assign o_instr_valid = w_head_match;
  assign o_instr_data  = w_empty ? 32'd0 : w_head.data;

  // Credit rule: queued + in-flight never exceeds DEPTH, so pushes cannot
  // overflow. Outputs depend only on registers, so they stay stable until
  // granted or the registers are rewritten by a flush.
  assign o_mem_req  = (r_state == ST_RUN) &&
                      (({1'b0, w_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH));
  assign o_mem_addr = {r_next_waddr, 2'b00};

  assign w_grant   = o_mem_req && i_mem_gnt;
  // A response with nothing in flight is a memory protocol error; ignore it.
  assign w_rsp_any = i_mem_rvalid && ((r_discard != '0) || (r_outstanding != '0));
  assign w_drop    = i_mem_rvalid && (r_discard != '0);
  assign w_accept  = i_mem_rvalid && (r_discard == '0) && (r_outstanding != '0) && !w_flush;
  assign w_pop     = i_fetch_pop && o_instr_valid && !w_flush;

  assign w_push_entry = '{waddr: 30'(r_resp_waddr), data: i_mem_rdata};

  always_comb begin
    w_discard_sum = '0;
    w_out_sum     = '0;
    if (w_flush) begin
      // Everything in flight, including a request granted this very cycle,
      // now belongs to the old stream. A response arriving now retires one.
      w_discard_sum = (CW+2)'(r_discard) + (CW+2)'(r_outstanding)
                    + (CW+2)'(w_grant) - (CW+2)'(w_rsp_any);
    end else begin
      w_discard_sum = (CW+2)'(r_discard) - (CW+2)'(w_drop);
      w_out_sum     = (CW+2)'(r_outstanding) + (CW+2)'(w_grant) - (CW+2)'(w_accept);
    end
    w_discard_next = (w_discard_sum > SAT_LIM) ? SAT_LIM[CW-1:0] : w_discard_sum[CW-1:0];
    w_out_next     = (w_out_sum > SAT_LIM) ? SAT_LIM[CW-1:0] : w_out_sum[CW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_BOOT;
      r_next_waddr  <= '0;
      r_resp_waddr  <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      if (r_state == ST_BOOT) r_state <= ST_RUN;
      r_outstanding <= w_out_next;
      r_discard     <= w_discard_next;
      if (w_flush) begin
        r_next_waddr <= w_fetch_waddr;
        r_resp_waddr <= w_fetch_waddr;
      end else begin
        if (w_grant)  r_next_waddr <= r_next_waddr + WW'(1);
        if (w_accept) r_resp_waddr <= r_resp_waddr + WW'(1);
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (w_accept),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_clear      (w_flush),
    .o_head       (w_head_bits),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count)
  );

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
`timescale 1ns/1ps
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_pop = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] instr_data;
  logic        instr_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t rq[$];

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_fetch_addr (fetch_addr),
    .i_fetch_pop  (fetch_pop),
    .i_redirect   (redirect),
    .o_instr_data (instr_data),
    .o_instr_valid(instr_valid),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
  );

  // Memory contents: word at address A is A ^ 0xDEAD0000.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD0000;
  endfunction

  // In-order memory: a grant at edge g returns its response for edge g+lat.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      rq.delete();
    end else begin
      if (mem_rvalid && rq.size() > 0) void'(rq.pop_front());
      if (mem_req && mem_gnt) rq.push_back('{mem_addr, cyc + lat});
    end
  end

  always @(negedge clk) begin
    if (reset_n && rq.size() > 0 && rq[0].due <= cyc + 1) begin
      mem_rvalid = 1'b1;
      mem_rdata  = word_at(rq[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  end

  // Queue overflow must never happen under the credit rule.
  always @(posedge clk) begin
    if (reset_n && dut.w_accept && dut.w_full) begin
      errors = errors + 1;
      $display("FAIL fifo_overflow: push while full at cycle %0d, required no push", cyc);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; fetch_addr = '0; fetch_pop = 1'b0; redirect = 1'b0; mem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b required 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h required 00000000", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b required 0", instr_valid); end
    checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_instr_data: got %h required 00000000", instr_data); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL boot_no_req: got %b required 0", mem_req); end
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL run_first_req: got req %b addr %h required 1 00000000", mem_req, mem_addr); end
    $display("test_reset: done, req=%b addr=%h", mem_req, mem_addr);
  endtask

  task automatic test_sequential();
    logic [31:0] exp_words [4];
    int got;
    exp_words = '{32'hDEAD0000, 32'hDEAD0004, 32'hDEAD0008, 32'hDEAD000C};
    got = 0;
    do_reset();
    lat = 1; mem_gnt = 1'b1;
    for (int t = 0; t < 40 && got < 4; t++) begin
      @(negedge clk);
      if (fetch_pop) fetch_addr = fetch_addr + 32'd4;
      fetch_pop = 1'b0;
      #1;
      checks++; if (mem_addr - fetch_addr > 32'd16) begin errors++; $display("FAIL seq_lookahead: mem_addr %h fetch_addr %h required at most 16 bytes ahead", mem_addr, fetch_addr); end
      if (instr_valid) begin
        checks++; if (instr_data !== exp_words[got]) begin errors++; $display("FAIL seq_word%0d: got %h required %h", got, instr_data, exp_words[got]); end
        $display("test_sequential: addr %h data %h", fetch_addr, instr_data);
        fetch_pop = 1'b1;
        got++;
      end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL seq_timeout: got %0d words required 4", got); end
    @(negedge clk); fetch_pop = 1'b0;
  endtask

  task automatic test_backpressure();
    int grants;
    logic [31:0] first_gnt_addr;
    do_reset();
    lat = 1; mem_gnt = 1'b1; grants = 0;
    for (int i = 0; i < 10; i++) begin
      #1; if (mem_req && mem_gnt) grants++;
      @(negedge clk);
    end
    #1;
    checks++; if (grants != 4) begin errors++; $display("FAIL bp_grants: got %0d required 4", grants); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_stopped: got %b required 0", mem_req); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL bp_addr_hold: got %h required 00000010", mem_addr); end
    checks++; if (instr_valid !== 1'b1 || instr_data !== 32'hDEAD0000) begin errors++; $display("FAIL bp_head: got %b %h required 1 DEAD0000", instr_valid, instr_data); end
    $display("test_backpressure: %0d grants, queue full", grants);
    fetch_pop = 1'b1;
    @(negedge clk);
    fetch_pop = 1'b0; fetch_addr = 32'h4;
    grants = 0; first_gnt_addr = '1;
    for (int i = 0; i < 6; i++) begin
      #1; if (mem_req && mem_gnt) begin if (grants == 0) first_gnt_addr = mem_addr; grants++; end
      @(negedge clk);
    end
    #1;
    checks++; if (grants != 1) begin errors++; $display("FAIL bp_refill_grants: got %0d required 1", grants); end
    checks++; if (first_gnt_addr !== 32'h10) begin errors++; $display("FAIL bp_refill_addr: got %h required 00000010", first_gnt_addr); end
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h14) begin errors++; $display("FAIL bp_refull: got req %b addr %h required 0 00000014", mem_req, mem_addr); end
    checks++; if (instr_valid !== 1'b1 || instr_data !== 32'hDEAD0004) begin errors++; $display("FAIL bp_head2: got %b %h required 1 DEAD0004", instr_valid, instr_data); end
    $display("test_backpressure: refill request to %h", first_gnt_addr);
  endtask

  task automatic test_redirect_inflight();
    bit seen;
    do_reset();
    lat = 5; mem_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_gnt = 1'b0; redirect = 1'b1; fetch_addr = 32'h100;
    @(negedge clk);
    redirect = 1'b0; mem_gnt = 1'b1;
    #1;
    checks++; if (dut.r_discard !== 3'd2) begin errors++; $display("FAIL rd_discard: got %0d required 2", dut.r_discard); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL rd_new_addr: got req %b addr %h required 1 00000100", mem_req, mem_addr); end
    @(negedge clk); #1;
    checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL rd_next_addr: got %h required 00000104", mem_addr); end
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (instr_valid) begin
        seen = 1;
        checks++; if (instr_data !== 32'hDEAD0100) begin errors++; $display("FAIL rd_first_word: got %h required DEAD0100", instr_data); end
        checks++; if (dut.r_discard !== 3'd0) begin errors++; $display("FAIL rd_discard_drained: got %0d required 0", dut.r_discard); end
        $display("test_redirect_inflight: first word %h", instr_data);
      end else begin
        @(negedge clk); #1;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rd_timeout: instr_valid 0 required 1 within 20 cycles"); end
  endtask

  task automatic test_redirect_grant();
    bit seen;
    do_reset();
    lat = 2; mem_gnt = 1'b0; redirect = 1'b1; fetch_addr = 32'h20;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL rg_setup: got req %b addr %h required 1 00000020", mem_req, mem_addr); end
    mem_gnt = 1'b1; redirect = 1'b1; fetch_addr = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL rg_new_addr: got %h required 00000040", mem_addr); end
    checks++; if (dut.r_discard !== 3'd1) begin errors++; $display("FAIL rg_discard: got %0d required 1", dut.r_discard); end
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (instr_valid) begin
        seen = 1;
        checks++; if (instr_data !== 32'hDEAD0040) begin errors++; $display("FAIL rg_first_word: got %h required DEAD0040", instr_data); end
        $display("test_redirect_grant: first word %h", instr_data);
      end else begin
        @(negedge clk); #1;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rg_timeout: instr_valid 0 required 1 within 20 cycles"); end
  endtask

  task automatic test_mismatch();
    bit seen;
    do_reset();
    lat = 1; mem_gnt = 1'b0; redirect = 1'b1; fetch_addr = 32'h8;
    @(negedge clk);
    redirect = 1'b0; mem_gnt = 1'b1;
    #1;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (instr_valid) seen = 1;
      else begin @(negedge clk); #1; end
    end
    checks++; if (!seen || instr_data !== 32'hDEAD0008) begin errors++; $display("FAIL mm_head8: got valid %b data %h required 1 DEAD0008", instr_valid, instr_data); end
    fetch_addr = 32'h30;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mm_miss_now: got %b required 0", instr_valid); end
    @(negedge clk); #1;
    checks++; if (mem_addr !== 32'h30) begin errors++; $display("FAIL mm_flush_addr: got %h required 00000030", mem_addr); end
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (instr_valid) begin
        seen = 1;
        checks++; if (instr_data !== 32'hDEAD0030) begin errors++; $display("FAIL mm_word30: got %h required DEAD0030", instr_data); end
        $display("test_mismatch: recovered word %h", instr_data);
      end else begin
        @(negedge clk); #1;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mm_timeout: instr_valid 0 required 1 within 20 cycles"); end
  endtask

  task automatic test_wrap_reset();
    bit seen;
    do_reset();
    lat = 1; mem_gnt = 1'b0; redirect = 1'b1; fetch_addr = 32'hFFFFFFFC;
    @(negedge clk);
    redirect = 1'b0; mem_gnt = 1'b1;
    #1;
    checks++; if (mem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wr_top_addr: got %h required FFFFFFFC", mem_addr); end
    @(negedge clk); #1;
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wr_wrap_addr: got %h required 00000000", mem_addr); end
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (instr_valid) seen = 1;
      else begin @(negedge clk); #1; end
    end
    checks++; if (!seen || instr_data !== 32'h2152FFFC) begin errors++; $display("FAIL wr_top_word: got valid %b data %h required 1 2152FFFC", instr_valid, instr_data); end
    fetch_pop = 1'b1;
    @(negedge clk);
    fetch_pop = 1'b0; fetch_addr = 32'h0;
    #1;
    checks++; if (instr_valid !== 1'b1 || instr_data !== 32'hDEAD0000) begin errors++; $display("FAIL wr_zero_word: got %b %h required 1 DEAD0000", instr_valid, instr_data); end
    $display("test_wrap_reset: wrapped to word %h", instr_data);
    reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 32'h0 || instr_data !== 32'h0) begin errors++; $display("FAIL wr_async_reset: got req %b valid %b addr %h data %h required 0 0 0 0", mem_req, instr_valid, mem_addr, instr_data); end
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL wr_hold_reset: got req %b valid %b required 0 0", mem_req, instr_valid); end
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL wr_after_reset: got req %b addr %h required 1 00000000", mem_req, mem_addr); end
    $display("test_wrap_reset: restart req=%b addr=%h", mem_req, mem_addr);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_grant();
    test_mismatch();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Sits directly upstream of the fetch stage, between instruction memory and fetch.
- Prefetches sequential 32-bit instruction words from a memory port with variable latency and a request/grant handshake.
- Holds the prefetched words in a small in-order queue and presents the word containing the fetch stage's requested address.
- On redirect (branch, jal, jalr, recovery), flushes the queue and discards in-flight responses.

Parameters:
- DEPTH, 4: queue entries; a power of two, at least 2.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- fetch_addr  in  ADDR_W  address driven by the fetch stage; bits [1:0] are ignored for matching.
- fetch_pop  in  1  fetch stage consumed the presented word and advances to the next word.
- redirect  in  1  control-flow change; the new stream starts at fetch_addr[ADDR_W-1:2].
- instr_data  out  32  word at the queue head.
- instr_valid  out  1  queue non-empty and head address equals fetch_addr[ADDR_W-1:2].
- mem_req  out  1  memory request.
- mem_addr  out  ADDR_W  word-aligned request address; bits [1:0] are always 0.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
- mem_rdata  in  32  response data.

Behaviour:
- Reset values: queue empty, pointers 0, outstanding=0, discard=0, next_addr=0. Outputs: mem_req=0, mem_addr=0, instr_valid=0, instr_data=0.
- State machine with two states:
  - BOOT, entered on reset; transitions to RUN one cycle after reset release.
  - RUN, the steady state. The first request goes to address 0.
- Issue: mem_req=1 in RUN when occupancy + outstanding < DEPTH.
  - mem_addr = next_addr.
  - On a cycle with mem_req && mem_gnt: outstanding increments and next_addr += 4. Wrap-around from 0xFFFFFFFC to 0 is silent.
  - mem_req and mem_addr stay stable until granted, except on redirect.
- Receive: mem_rvalid with discard=0 pushes {word address, mem_rdata} and decrements outstanding.
  - The tag is a separate register, resp_addr, that advances by 4 per accepted response.
  - Overflow is impossible by the credit rule. The bench asserts this.
- Present: instr_valid and instr_data are combinational from the head. There is zero latency from the fetch_addr change to the hit.
- Pop: fetch_pop && instr_valid removes the head. fetch_pop without instr_valid is ignored.
- Auto-miss: if the queue is non-empty, the head does not match, and redirect=0, the block behaves as if redirect were asserted that cycle. The fetch stage is thereby self-healing.
- Redirect, in the same cycle:
  - Queue cleared.
  - discard += outstanding, plus 1 if mem_gnt is asserted this cycle.
  - outstanding = 0.
  - next_addr and resp_addr = {fetch_addr[ADDR_W-1:2], 2'b00}.
  - The request issued the following cycle targets the new address.
- Discard: mem_rvalid while discard>0 decrements discard; the data is dropped and not pushed.
- Simultaneous events:
  - redirect + fetch_pop: redirect wins.
  - redirect + mem_rvalid: the response is discarded; it belonged to the old stream.
  - Push and pop in the same cycle: occupancy is unchanged.
  - Full queue: mem_req=0, and the queue holds until a pop or redirect.
- Counter widths: pointers are $clog2(DEPTH)+1 bits so full and empty are distinct. outstanding and discard are $clog2(DEPTH)+1 bits and saturate-assert (error) on overflow.
- Reset asserted mid-operation clears everything immediately. Responses that arrive after reset release are memory's responsibility (memory is reset by the same reset_n).

Decomposition:
- common package additions:
  - typedef prefetch_entry_t {logic [29:0] waddr; logic [31:0] data;}
  - constant PREFETCH_DEPTH = 4.
- One sub-module, prefetch_fifo: synchronous FIFO of prefetch_entry_t with push, pop, clear, full, empty and count outputs.
- The top level holds the FSM, the credit counters and the address registers.

Test Plan:
- Sequential stream: memory latency 1, gnt always 1, fetch_pop every cycle once valid. Required: instr_data sequence is the words at 0x0, 0x4, 0x8, 0xC; mem_addr never exceeds 4 words ahead.
- Backpressure: no fetch_pop for 10 cycles. Required: exactly DEPTH=4 grants, then mem_req=0; one pop then yields exactly one new request, to 0x10.
- Redirect with 2 responses in flight, redirect to fetch_addr=0x100. Required: discard=2; the next 2 rvalids are dropped; the first presented word is the one at 0x100 with instr_valid=1; the next mem_addr is 0x104.
- Redirect in the same cycle as a grant to 0x20, with fetch_addr=0x40. Required: the 0x20 response is discarded and mem_addr=0x40 the next cycle.
- Mismatch: head=0x8, fetch_addr=0x30, no redirect. Required: auto-flush, instr_valid=0 until the word at 0x30 arrives.
- Wrap and reset: redirect to 0xFFFFFFFC, then assert reset_n=0 mid-stream. Required: the request after 0xFFFFFFFC is 0x0; during reset mem_req=0 and instr_valid=0; after reset the first mem_addr is 0x0.
